// File: rtl/cpu_ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the reset fetch address default and the instruction word type.
package cpu_ifetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hFFFF0000;

    typedef logic [INSTR_W-1:0] instr_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Prefetch FIFO for fetched instruction words; flush overrides push.
// DEPTH must be a power of two so the pointers wrap naturally.
module cpu_ifetch_fifo
    import cpu_ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  instr_t                 wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output instr_t                 head
);

    localparam int AW = $clog2(DEPTH);

    instr_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_ifetch.sv
// P1 instruction fetch: issues sequential requests, buffers in-order responses
// and presents one instruction per cycle on the registered P2 outputs.
module cpu_ifetch
    import cpu_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        p2_bubble,
    input  logic        p4_jump_taken,
    input  logic [31:0] p4_jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  instr_t      imem_rdata,
    output instr_t      p2_instr,
    output logic [31:0] p2_pc,
    output logic        p2_instr_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    instr_t        p2_instr_q, p2_instr_d;
    logic [31:0]   p2_pc_q, p2_pc_d;
    logic          p2_valid_q, p2_valid_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    instr_t        fifo_head;

    logic          redirect, grant, deliver, advance, fifo_pop, bypass, fifo_push;
    logic [CW:0]   inflight_total;
    logic [31:0]   jump_target;

    assign redirect       = p4_jump_taken && !stall;
    assign jump_target    = word_align(p4_jump_addr);
    assign inflight_total = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req       = !reset && !redirect && (inflight_total < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign grant          = imem_req && imem_gnt;
    assign deliver        = imem_rvalid && (discard_q == '0);
    assign advance        = !stall && !p2_bubble && !redirect;
    assign fifo_pop       = advance && !fifo_empty;
    assign bypass         = advance && fifo_empty && deliver;
    assign fifo_push      = deliver && !bypass;

    cpu_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .wdata (imem_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d = jump_target;
            // Every request still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (grant) fetch_pc_d = pc_incr(fetch_pc_q);
            if (imem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_comb begin
        p2_instr_d = p2_instr_q;
        p2_pc_d    = p2_pc_q;
        p2_valid_d = p2_valid_q;
        head_pc_d  = head_pc_q;
        if (redirect) begin
            p2_valid_d = 1'b0;
            head_pc_d  = jump_target;
        end else if (advance) begin
            if (fifo_pop) begin
                p2_instr_d = fifo_head;
                p2_pc_d    = head_pc_q;
                p2_valid_d = 1'b1;
                head_pc_d  = pc_incr(head_pc_q);
            end else if (bypass) begin
                p2_instr_d = imem_rdata;
                p2_pc_d    = head_pc_q;
                p2_valid_d = 1'b1;
                head_pc_d  = pc_incr(head_pc_q);
            end else begin
                p2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            p2_instr_q    <= '0;
            p2_pc_q       <= '0;
            p2_valid_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            p2_instr_q    <= p2_instr_d;
            p2_pc_q       <= p2_pc_d;
            p2_valid_q    <= p2_valid_d;
        end
    end

    // The request throttle keeps a free FIFO slot for every returning word.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(imem_rvalid && fifo_full));
            assert (!(imem_rvalid && outstanding_q == '0));
        end
    end

    assign p2_instr       = p2_instr_q;
    assign p2_pc          = p2_pc_q;
    assign p2_instr_valid = p2_valid_q;

endmodule
